// File: rtl/poly_intp_sched.sv
// Input scheduler and double-buffered tap bank for the polyphase interpolator.
// Optional statistics counters are enabled by defining POLY_SCHED_STATS_EN.
module poly_intp_sched #(
    parameter int RATE       = 4,
    parameter int M_RATE     = 2,
    parameter int TAP_LEN    = 16,
    parameter int WIDTH      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic signed [WIDTH-1:0]     s_data,
    output logic                        cke,
    output logic signed [WIDTH-1:0]     din,
    input  logic                        tap_wr,
    input  logic [$clog2(TAP_LEN)-1:0]  tap_addr,
    input  logic signed [WIDTH-1:0]     tap_wdata,
    input  logic                        tap_swap,
    output logic                        swap_done,
    output logic [TAP_LEN*WIDTH-1:0]    tap,
`ifdef POLY_SCHED_STATS_EN
    output logic [31:0]                 stat_in,
    output logic [15:0]                 stat_urun,
`endif
    output logic                        underrun
);

    localparam int PERIOD = RATE * M_RATE;
    localparam int PCW    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;
    localparam int AW     = $clog2(TAP_LEN);

    logic [PCW-1:0]            pc_q, pc_d;
    logic signed [WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic signed [WIDTH-1:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic                      ready_q, ready_d;
    logic signed [WIDTH-1:0]   bank_q [2][TAP_LEN];
    logic signed [WIDTH-1:0]   bank_d [2][TAP_LEN];
    logic                      sel_q, sel_d, pend_q, pend_d;
    logic                      cke_q, cke_d, swap_done_q, swap_done_d, urun_q, urun_d;
    logic signed [WIDTH-1:0]   din_q, din_d;
    logic [TAP_LEN*WIDTH-1:0]  tap_q, tap_d;

    logic issue, empty, push, pop, addr_ok;

    assign issue   = en && (pc_q == '0);
    assign empty   = (count_q == '0);
    assign push    = s_valid && ready_q;
    assign pop     = issue && !empty;
    assign addr_ok = ({1'b0, tap_addr} < (AW+1)'(TAP_LEN));

    always_comb begin
        if (!en)
            pc_d = '0;
        else if (pc_q == PCW'(PERIOD - 1))
            pc_d = '0;
        else
            pc_d = pc_q + 1'b1;
    end

    // A word pushed into an empty FIFO during an issue clock is not popped until the next period.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = s_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
        ready_d = (count_d != CW'(FIFO_DEPTH));
    end

    always_comb begin
        cke_d       = issue;
        din_d       = pop ? mem_q[rd_ptr_q] : '0;
        urun_d      = urun_q | (issue & empty);
        swap_done_d = issue & pend_q;
        sel_d       = sel_q ^ (issue & pend_q);
        pend_d      = issue ? tap_swap : (pend_q | tap_swap);
    end

    // Writes always target the bank that is shadow before this clock's swap,
    // so a write in the apply clock lands in the newly active bank.
    always_comb begin
        bank_d = bank_q;
        if (tap_wr && addr_ok)
            bank_d[~sel_q][tap_addr] = tap_wdata;
        tap_d = '0;
        for (int k = 0; k < TAP_LEN; k++)
            tap_d[k*WIDTH +: WIDTH] = bank_d[sel_d][k];
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b1;
            bank_q      <= '{default: '{default: '0}};
            sel_q       <= 1'b0;
            pend_q      <= 1'b0;
            cke_q       <= 1'b0;
            din_q       <= '0;
            swap_done_q <= 1'b0;
            urun_q      <= 1'b0;
            tap_q       <= '0;
        end else begin
            pc_q        <= pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ready_q     <= ready_d;
            bank_q      <= bank_d;
            sel_q       <= sel_d;
            pend_q      <= pend_d;
            cke_q       <= cke_d;
            din_q       <= din_d;
            swap_done_q <= swap_done_d;
            urun_q      <= urun_d;
            tap_q       <= tap_d;
        end
    end

`ifdef POLY_SCHED_STATS_EN
    logic [31:0] stat_in_q, stat_in_d;
    logic [15:0] stat_urun_q, stat_urun_d;

    always_comb begin
        stat_in_d   = stat_in_q + (push ? 32'd1 : 32'd0);
        stat_urun_d = stat_urun_q;
        if (issue && empty && (stat_urun_q != 16'hFFFF))
            stat_urun_d = stat_urun_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_in_q   <= '0;
            stat_urun_q <= '0;
        end else begin
            stat_in_q   <= stat_in_d;
            stat_urun_q <= stat_urun_d;
        end
    end

    assign stat_in   = stat_in_q;
    assign stat_urun = stat_urun_q;
`endif

    assign s_ready   = ready_q;
    assign cke       = cke_q;
    assign din       = din_q;
    assign swap_done = swap_done_q;
    assign tap       = tap_q;
    assign underrun  = urun_q;

endmodule

// File: tb/tb_poly_intp_sched.sv
// Scoreboard bench for poly_intp_sched: a queue-based reference model predicts
// every cke event; a negedge monitor pops and compares.
module tb_poly_intp_sched;
    localparam int PERIOD = 8;
    localparam int DEPTH  = 8;

    logic         clk = 1'b0;
    logic         rst, en, s_valid, s_ready, cke, tap_wr, tap_swap, swap_done, underrun;
    logic [15:0]  s_data, din, tap_wdata;
    logic [3:0]   tap_addr;
    logic [255:0] tap;
`ifdef POLY_SCHED_STATS_EN
    logic [31:0]  stat_in;
    logic [15:0]  stat_urun;
`endif

    always #5 clk = ~clk;

    poly_intp_sched #(.RATE(4), .M_RATE(2), .TAP_LEN(16), .WIDTH(16), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .cke(cke), .din(din), .tap_wr(tap_wr), .tap_addr(tap_addr), .tap_wdata(tap_wdata),
        .tap_swap(tap_swap), .swap_done(swap_done), .tap(tap),
`ifdef POLY_SCHED_STATS_EN
        .stat_in(stat_in), .stat_urun(stat_urun),
`endif
        .underrun(underrun)
    );

    typedef struct {
        logic [15:0]  din;
        logic         sd;
        logic [255:0] tap;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mq[$];
    logic [15:0] mb[2][16];
    int          pc;
    bit          pend, sel, urun, last_issue;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] packb(input bit s);
        logic [255:0] r;
        for (int k = 0; k < 16; k++) r[k*16 +: 16] = mb[s][k];
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        pc = 0; pend = 0; sel = 0; urun = 0; last_issue = 0;
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < 16; k++) mb[b][k] = '0;
    endtask

    // One clock of stimulus; the model advances by the behavioural rules.
    task automatic cyc(input bit v, input logic [15:0] d, input bit e, input bit w,
                       input logic [3:0] a, input logic [15:0] wd, input bit sw);
        exp_t x;
        bit   issue, oldsel, accept;
        s_valid = v; s_data = d; en = e; tap_wr = w; tap_addr = a; tap_wdata = wd; tap_swap = sw;
        accept = v && (mq.size() < DEPTH);
        issue  = e && (pc == 0);
        oldsel = sel;
        x.din = '0; x.sd = 1'b0; x.tap = '0;
        if (issue) begin
            if (mq.size() > 0) x.din = mq.pop_front();
            else begin x.din = '0; urun = 1; end
            x.sd = pend;
            if (pend) sel = !sel;
            pend = sw;
        end else begin
            pend = pend | sw;
        end
        if (w) mb[!oldsel][a] = wd;
        if (accept) mq.push_back(d);
        if (issue) begin
            x.tap = packb(sel);
            exp_q.push_back(x);
        end
        pc = e ? (pc + 1) % PERIOD : 0;
        last_issue = issue;
        @(posedge clk);
        #1;
        chk("s_ready", s_ready, (mq.size() < DEPTH));
        chk("underrun", underrun, urun);
        chk("cke", cke, issue);
        if (!issue) chk("tap_hold", tap, packb(sel));
        @(negedge clk);
        #1;
        chk("cke_missing", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic idle(input int n, input bit e);
        repeat (n) cyc(0, '0, e, 0, '0, '0, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (cke) begin
                if (exp_q.size() == 0) chk("cke_unexpected", cke, 0);
                else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    chk("din", din, x.din);
                    chk("swap_done", swap_done, x.sd);
                    chk("tap_at_cke", tap, x.tap);
                end
            end else if (swap_done) begin
                chk("swap_done_stray", swap_done, 0);
            end
        end
    end

    initial begin
        rst = 1; en = 0; s_valid = 0; s_data = '0; tap_wr = 0; tap_addr = '0;
        tap_wdata = '0; tap_swap = 0;
        model_reset();
        #12;
        chk("rst_cke", cke, 0);
        chk("rst_din", din, 0);
        chk("rst_ready", s_ready, 1);
        chk("rst_swap_done", swap_done, 0);
        chk("rst_tap", tap, 0);
        chk("rst_underrun", underrun, 0);
        #1 rst = 0;
        @(negedge clk); #1;

        // Three samples queued, then enabled: 100,200,300 then zero-stuff.
        cyc(1, 16'd100, 0, 0, '0, '0, 0);
        cyc(1, 16'd200, 0, 0, '0, '0, 0);
        cyc(1, 16'd300, 0, 0, '0, '0, 0);
        idle(40, 1);
        chk("underrun_after_drain", underrun, 1);

        // Backpressure with en low, then drain.
        for (int i = 0; i < 12; i++) cyc(1, 16'(1000 + i), 0, 0, '0, '0, 0);
        chk("ready_low_when_full", s_ready, 0);
        idle(70, 1);

        // Shadow bank load k -> k+1, swap requested mid-period.
        for (int k = 0; k < 16; k++) cyc(0, '0, 1, 1, 4'(k), 16'(k + 1), 0);
        while (pc == 0) idle(1, 1);
        cyc(0, '0, 1, 0, '0, '0, 1);
        idle(20, 1);
        for (int k = 0; k < 16; k++)
            chk("tap_loaded", tap[k*16 +: 16], 16'(k + 1));

        // Swap requested in the issue clock itself; then two merged pulses.
        while (pc != 0) idle(1, 1);
        cyc(0, '0, 1, 0, '0, '0, 1);
        idle(20, 1);
        while (pc != 2) idle(1, 1);
        cyc(0, '0, 1, 0, '0, '0, 1);
        idle(1, 1);
        cyc(0, '0, 1, 0, '0, '0, 1);
        idle(20, 1);

        // Push into an empty FIFO on the issue clock.
        while (pc != 0) idle(1, 1);
        cyc(1, 16'd55, 1, 0, '0, '0, 0);
        idle(16, 1);

        // Randomized traffic, tap writes and swaps.
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 9) != 0,
                $urandom_range(0, 3) == 0, 4'($urandom), 16'($urandom),
                $urandom_range(0, 15) == 0);

        // Async reset mid-period with samples queued and a swap pending.
        while (pc != 0) idle(1, 1);
        for (int i = 0; i < 6; i++) cyc(1, 16'(7 + i), 1, 0, '0, '0, 0);
        cyc(0, '0, 1, 0, '0, '0, 1);
        s_valid = 0; en = 0; tap_wr = 0; tap_swap = 0;
        #2 rst = 1;
        #1;
        chk("arst_cke", cke, 0);
        chk("arst_din", din, 0);
        chk("arst_ready", s_ready, 1);
        chk("arst_swap_done", swap_done, 0);
        chk("arst_tap", tap, 0);
        chk("arst_underrun", underrun, 0);
        model_reset();
        @(posedge clk);
        #3 rst = 0;
        @(negedge clk); #1;
        idle(4, 0);
        idle(30, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
